// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared types and helpers for the stopwatch core
//
// Contents:
//   state_t          control FSM state (IDLE/RUN/PAUSE/DONE)
//   DEFAULT_TICK_DIV default clk cycles per one-second tick
//   clog2()          ceiling log2, used to size counters from their modulus
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int DEFAULT_TICK_DIV = 100_000_000;

  // clog2(1) = 0, clog2(60) = 6, clog2(256) = 8
  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - modulo-MOD up/down counter with carry/borrow output
//
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          advance one step this cycle
//   up          1 = increment, 0 = decrement
//   load        synchronous load of load_val (wins over en)
//   load_val    value to load
//   value       current count, 0..MOD-1
//   wrap        high when an enabled step rolls over (carry when up, borrow when down)
module mod_counter #(
  parameter int MOD   = 60,
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] value,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] TOP = WIDTH'(MOD - 1);

  assign wrap = en && (up ? (value == TOP) : (value == '0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en) begin
      if (up) begin
        value <= (value == TOP) ? '0 : value + 1'b1;
      end else begin
        value <= (value == '0) ? TOP : value - 1'b1;
      end
    end
  end

endmodule

// File: rtl/stopwatch_time_counter.sv
// rtl/stopwatch_time_counter.sv - minutes:seconds stopwatch/timer with one-second prescaler
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clear               synchronous clear of time, prescaler and overflow
//   start, stop         resume / pause pulses (stop wins when both are high)
//   count_down          direction, sampled on every tick
//   load                preset strobe for load_min/load_sec (values clamped to range)
//   minutes, seconds    current time
//   running, done       FSM in RUN / DONE
//   sec_tick            one-cycle pulse while a freshly updated time is visible
//   overflow            sticky flag for count-up past MIN_MAX:SEC_MOD-1
module stopwatch_time_counter
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV  = DEFAULT_TICK_DIV,
  parameter int SEC_MOD   = 60,
  parameter int MIN_WIDTH = 8,
  parameter int MIN_MAX   = 255,
  parameter int SATURATE  = 0,
  localparam int SEC_W    = clog2(SEC_MOD)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 count_down,
  input  logic                 load,
  input  logic [MIN_WIDTH-1:0] load_min,
  input  logic [SEC_W-1:0]     load_sec,
  output logic [MIN_WIDTH-1:0] minutes,
  output logic [SEC_W-1:0]     seconds,
  output logic                 running,
  output logic                 sec_tick,
  output logic                 done,
  output logic                 overflow
);

  localparam int                   PW      = (TICK_DIV > 1) ? clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]        PRE_TOP = PW'(TICK_DIV - 1);
  localparam logic [SEC_W-1:0]     SEC_TOP = SEC_W'(SEC_MOD - 1);
  localparam logic [MIN_WIDTH-1:0] MIN_TOP = MIN_WIDTH'(MIN_MAX);

  state_t                 state;
  state_t                 state_nxt;
  logic [PW-1:0]          presc;
  logic                   tick;
  logic                   up;
  logic                   at_top;
  logic                   at_zero;
  logic                   at_one;
  logic                   sat_hold;
  logic                   step;
  logic                   ctr_load;
  logic [SEC_W-1:0]       sec_load_val;
  logic [MIN_WIDTH-1:0]   min_load_val;
  logic                   sec_wrap;
  logic                   min_wrap;

  assign up       = ~count_down;
  assign at_top   = (minutes == MIN_TOP) && (seconds == SEC_TOP);
  assign at_zero  = (minutes == '0) && (seconds == '0);
  assign at_one   = (minutes == '0) && (seconds == SEC_W'(1));

  // A tick only exists in RUN when no higher-priority control is acting this cycle.
  assign tick     = (state == RUN) && !clear && !load && !stop && (presc == PRE_TOP);

  // Ticks that leave the time untouched: saturating at the top, or counting down from 00:00.
  assign sat_hold = up && at_top && (SATURATE != 0);
  assign step     = tick && !sat_hold && !(!up && at_zero);

  // clear is folded into the counters' load path with a zero preset.
  assign ctr_load     = clear | load;
  assign sec_load_val = clear ? '0 : ((load_sec > SEC_TOP) ? SEC_TOP : load_sec);
  assign min_load_val = clear ? '0 : ((load_min > MIN_TOP) ? MIN_TOP : load_min);

  mod_counter #(
    .MOD   (SEC_MOD),
    .WIDTH (SEC_W)
  ) u_sec (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (step),
    .up       (up),
    .load     (ctr_load),
    .load_val (sec_load_val),
    .value    (seconds),
    .wrap     (sec_wrap)
  );

  mod_counter #(
    .MOD   (MIN_MAX + 1),
    .WIDTH (MIN_WIDTH)
  ) u_min (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (sec_wrap),
    .up       (up),
    .load     (ctr_load),
    .load_val (min_load_val),
    .value    (minutes),
    .wrap     (min_wrap)
  );

  always_comb begin
    state_nxt = state;
    if (clear || load) begin
      state_nxt = IDLE;
    end else if (stop) begin
      // stop suppresses a simultaneous start even when it has nothing to pause
      if (state == RUN) state_nxt = PAUSE;
    end else if (start && (state == IDLE || state == PAUSE)) begin
      state_nxt = RUN;
    end else if (tick) begin
      if (sat_hold) begin
        state_nxt = DONE;
      end else if (!up && (at_zero || at_one)) begin
        state_nxt = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Prescaler keeps its phase across PAUSE so a resume finishes the partial second.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (ctr_load) begin
      presc <= '0;
    end else if (state == RUN) begin
      if (!stop) presc <= (presc == PRE_TOP) ? '0 : presc + 1'b1;
    end else if (state != PAUSE) begin
      presc <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      sec_tick <= 1'b0;
    end else begin
      sec_tick <= step;
      if (clear) begin
        overflow <= 1'b0;
      end else if (tick && up && at_top) begin
        overflow <= 1'b1;
      end
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

endmodule

// File: doc/stopwatch_time_counter.md
Name: stopwatch_time_counter

Overview:
Parametrised minutes:seconds stopwatch/timer core with a built-in one-second prescaler.
- Run/pause/done control FSM, up or down counting, and preset load.
- Selectable wrap or saturate at the top of range.
- Replaces the bare enable-driven minutes counter.
- Sits between the button debounce/control logic and the display encoder.

Parameters:
TICK_DIV, 100000000, clk cycles per one-second tick (>=1)
SEC_MOD, 60, seconds modulus (2..256)
MIN_WIDTH, 8, minutes register width
MIN_MAX, 255, largest minutes value (<= 2^MIN_WIDTH-1)
SATURATE, 0, count-up top behaviour: 0 = wrap to 00:00, 1 = hold and stop

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
clear  in  1  synchronous clear, single-cycle or level
start  in  1  start/resume pulse
stop  in  1  pause pulse
count_down  in  1  0 = count up, 1 = count down; sampled every tick
load  in  1  synchronous preset strobe
load_min  in  MIN_WIDTH  preset minutes
load_sec  in  SEC_W  preset seconds; SEC_W = clog2(SEC_MOD)
minutes  out  MIN_WIDTH  current minutes
seconds  out  SEC_W  current seconds
running  out  1  high in RUN
sec_tick  out  1  one-cycle pulse on each counter update
done  out  1  high in DONE
overflow  out  1  sticky, set on count-up wrap or saturate

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0, prescaler 0, state IDLE.
- Control priority, highest first: clear > load > stop > start.
- FSM states: IDLE, RUN, PAUSE, DONE.
  - IDLE: start -> RUN.
  - RUN: stop -> PAUSE; terminal condition -> DONE.
  - PAUSE: start -> RUN.
  - DONE: leaves only on clear (-> IDLE) or load (-> IDLE).
- clear, any state: minutes/seconds/prescaler/overflow -> 0; state -> IDLE.
- load, any state:
  - minutes <= load_min, seconds <= load_sec; prescaler -> 0; state -> IDLE; overflow unchanged.
  - load_sec >= SEC_MOD is clamped to SEC_MOD-1.
  - load_min > MIN_MAX is clamped to MIN_MAX.
- Prescaler:
  - Counts 0..TICK_DIV-1 only in RUN; frozen in PAUSE, so a resume keeps the partial second.
  - Held at 0 in IDLE/DONE.
  - Terminal count produces an internal tick.
- Tick latency: minutes/seconds change on the same edge the prescaler wraps.
  - sec_tick is high the cycle after that edge, i.e. while the new value is visible.
- Count up, per tick:
  - seconds+1; at SEC_MOD-1, seconds -> 0 and minutes+1.
  - At MIN_MAX:SEC_MOD-1 with SATURATE=0: next value 00:00, overflow <= 1, stay in RUN.
  - At MIN_MAX:SEC_MOD-1 with SATURATE=1: value holds, overflow <= 1, state -> DONE, no sec_tick.
- Count down, per tick:
  - seconds-1; at 0, seconds -> SEC_MOD-1 and minutes-1.
  - The tick that reaches 00:00 moves the state to DONE on the same edge.
  - Starting at 00:00 in count-down: the first tick produces no change; state -> DONE.
- start in RUN/DONE and stop in IDLE/PAUSE/DONE: ignored.
- start and stop in the same cycle: stop wins.
- count_down change mid-second: takes effect on the next tick; the prescaler is not reset.
- TICK_DIV=1: tick every RUN cycle.

Decomposition:
- stopwatch_pkg holds:
  - state enum (IDLE/RUN/PAUSE/DONE), 2 bits;
  - clog2 function used to derive SEC_W;
  - shared default TICK_DIV constant.
- Natural sub-module: mod_counter.
  - Parameters: MOD, WIDTH.
  - Inputs: en, up, load, load_val.
  - Outputs: value, wrap (carry/borrow).
  - Instantiated twice (seconds, minutes), chained by wrap -> en.
- Prescaler and FSM stay in the top.

Test Plan:
All scenarios use TICK_DIV=4, SEC_MOD=60, MIN_MAX=3.
- Reset mid-count: rst_n low at 01:30 -> outputs 0 immediately, without a clock edge; state IDLE.
- Basic count: start, run 4*61 cycles -> 01:01, 61 sec_tick pulses each one cycle wide, running=1.
- Pause/resume: stop 2 cycles into a second, hold 10 cycles, start -> next tick after the remaining 2 cycles; value unchanged while paused.
- Wrap (SATURATE=0): load 03:59, start, 1 tick -> 00:00, overflow=1, still running. Repeat with SATURATE=1 -> holds 03:59, done=1, running=0.
- Countdown: load 00:02, count_down=1, start -> 00:01, then 00:00 with done=1 on the same edge. Further start is ignored; clear -> IDLE, done=0.
- Priority: assert clear+load+start in one cycle at 02:10 -> 00:00, IDLE, overflow cleared. Assert start+stop in RUN -> PAUSE.
